// File: rtl/fifo_drain_arbiter.sv
// Read-side scheduler: drains CH FIFOs one word at a time onto a valid/ready stream, tagging each word with its channel.
// ARB_FIXED_PRIO_EN selects lowest-index priority with drain-until-empty grants instead of round-robin bursts.
module fifo_drain_arbiter #(
  parameter int N     = 8,
  parameter int CH    = 4,
  parameter int CH_W  = 2,
  parameter int BURST = 4
) (
  input  logic              clk_out,
  input  logic              arst,
  input  logic [CH-1:0]     fifo_empty,
  input  logic [CH*N-1:0]   fifo_data,
  output logic [CH-1:0]     fifo_rd,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N-1:0]      m_data,
  output logic [CH_W-1:0]   m_ch,
  output logic              busy
);

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RD, CAP, OUT} state_t;

  state_t              state, state_nxt;
  logic [CH_W-1:0]     grant, grant_nxt, rr_ptr, rr_ptr_nxt, pick, grant_inc;
  logic [7:0]          burst_cnt, burst_cnt_nxt;
  logic                m_valid_nxt;
  logic [N-1:0]        m_data_nxt;
  logic [CH_W-1:0]     m_ch_nxt;
  logic                any_ne, more;
  logic [CH-1:0][N-1:0] fifo_word;

  assign fifo_word = fifo_data;
  assign any_ne    = ~&fifo_empty;
  assign busy      = (state != IDLE);
  assign grant_inc = (grant == CH_W'(CH - 1)) ? '0 : grant + CH_W'(1);

  // Read strobe is purely decoded so reset kills it without waiting for a clock.
  for (genvar k = 0; k < CH; k++) begin : g_rd
    assign fifo_rd[k] = (state == RD) && (grant == CH_W'(k)) && !fifo_empty[k];
  end

  // Rotating search from rr_ptr; rr_ptr stays 0 in fixed-priority mode, which
  // turns the same search into lowest-index-wins.
  always_comb begin
    logic            found;
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] idx;
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < CH; i++) begin
      sum = {1'b0, rr_ptr} + (CH_W + 1)'(i);
      if (sum >= (CH_W + 1)'(CH)) sum = sum - (CH_W + 1)'(CH);
      idx = sum[CH_W-1:0];
      if (!found && !fifo_empty[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign more = FIXED_PRIO ? !fifo_empty[grant]
                           : (burst_cnt < 8'(BURST)) && !fifo_empty[grant];

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    m_valid_nxt   = m_valid;
    m_data_nxt    = m_data;
    m_ch_nxt      = m_ch;
    case (state)
      IDLE: if (any_ne) begin
        grant_nxt     = pick;
        burst_cnt_nxt = '0;
        state_nxt     = RD;
      end
      RD: if (fifo_empty[grant]) begin
        rr_ptr_nxt = FIXED_PRIO ? '0 : grant_inc;
        state_nxt  = IDLE;
      end else begin
        state_nxt = CAP;
      end
      CAP: begin
        m_data_nxt    = fifo_word[grant];
        m_ch_nxt      = grant;
        m_valid_nxt   = 1'b1;
        burst_cnt_nxt = burst_cnt + 8'd1;
        state_nxt     = OUT;
      end
      OUT: if (m_valid && m_ready) begin
        m_valid_nxt = 1'b0;
        if (more) begin
          state_nxt = RD;
        end else begin
          rr_ptr_nxt = FIXED_PRIO ? '0 : grant_inc;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_out or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_ch      <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
      m_valid   <= m_valid_nxt;
      m_data    <= m_data_nxt;
      m_ch      <= m_ch_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: FIFO-bank model, directed timing checks and randomized drains
// compared against an order model built from the grant rules.
module tb_fifo_drain_arbiter;
  localparam int N = 8, CH = 4, CH_W = 2, BURST = 4;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk_out = 1'b0;
  logic              arst = 1'b1;
  logic [CH-1:0]     fifo_empty = '1;
  logic [CH*N-1:0]   fifo_data = '0;
  logic [CH-1:0]     fifo_rd;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [N-1:0]      m_data;
  logic [CH_W-1:0]   m_ch;
  logic              busy;

  always #5 clk_out = ~clk_out;

  fifo_drain_arbiter #(.N(N), .CH(CH), .CH_W(CH_W), .BURST(BURST)) dut (
    .clk_out(clk_out), .arst(arst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_ch(m_ch), .busy(busy)
  );

  // FIFO bank: words ever loaded per channel plus a read index owned here.
  logic [N-1:0] ldq [CH][$];
  int           rdptr [CH] = '{default: 0};
  always @(posedge clk_out) begin
    for (int k = 0; k < CH; k++) begin
      int rp;
      rp = rdptr[k];
      if (fifo_rd[k] && !fifo_empty[k]) begin
        fifo_data[k*N +: N] <= ldq[k][rp];
        rp++;
      end
      rdptr[k]      <= rp;
      fifo_empty[k] <= (rp >= ldq[k].size());
    end
  end

  // Output monitor
  logic [15:0]     got[$];
  int              nstrobe = 0, bad_rd = 0, bad_hold = 0;
  logic            pv = 1'b0, pr = 1'b0;
  logic [N-1:0]    pd = '0;
  logic [CH_W-1:0] pc = '0;
  always @(negedge clk_out) begin
    if (fifo_rd != '0) nstrobe++;
    if ($countones(fifo_rd) > 1) bad_rd++;
    if (!arst && pv && !pr && (!m_valid || m_data !== pd || m_ch !== pc)) bad_hold++;
    if (m_valid && m_ready) got.push_back({8'(m_ch), m_data});
    pv = m_valid; pr = m_ready; pd = m_data; pc = m_ch;
  end

  // Reference: per-channel content queues and the service order they imply.
  logic [N-1:0] mq [CH][$];
  int           mptr = 0;
  logic [15:0]  expq[$];
  int           tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int k, input logic [N-1:0] d, input bit model);
    ldq[k].push_back(d);
    if (model) mq[k].push_back(d);
  endtask

  task automatic predict(output int n);
    n = 0;
    while (1) begin
      int g;
      g = -1;
      for (int i = 0; i < CH; i++) begin
        int c;
        c = (mptr + i) % CH;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
      if (g < 0) break;
      for (int t = 0; (FIXED || t < BURST) && mq[g].size() > 0; t++) begin
        expq.push_back({8'(g), mq[g].pop_front()});
        n++;
      end
      mptr = FIXED ? 0 : (g + 1) % CH;
    end
  endtask

  task automatic drain(input string tag, input bit rnd, input int s_got, input int s_str);
    int n, c, eb;
    eb = expq.size();
    predict(n);
    c = 0;
    while (!((got.size() - s_got) >= n && !busy) && c < 2000) begin
      @(posedge clk_out); #1;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      c++;
    end
    chk({tag, " timeout"}, 32'(c < 2000), 32'd1);
    chk({tag, " count"}, 32'(got.size() - s_got), 32'(n));
    for (int i = 0; i < n; i++)
      if (s_got + i < got.size()) chk({tag, " word"}, 32'(got[s_got + i]), 32'(expq[eb + i]));
    chk({tag, " strobes"}, 32'(nstrobe - s_str), 32'(n));
    chk({tag, " onehot"}, 32'(bad_rd), 32'd0);
    chk({tag, " hold"}, 32'(bad_hold), 32'd0);
    @(posedge clk_out); #1;
    m_ready = 1'b1;
  endtask

  initial begin
    int sg, ss, c, n;
    repeat (3) @(posedge clk_out);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst m_valid", 32'(m_valid), 32'd0);
    chk("rst m_data", 32'(m_data), 32'd0);
    chk("rst m_ch", 32'(m_ch), 32'd0);
    @(negedge clk_out); arst = 1'b0;

    // Single word on ch1: strobe, capture and present latency
    m_ready = 1'b1;
    sg = got.size(); ss = nstrobe;
    @(negedge clk_out); load(1, 8'hA5, 1'b1);
    c = 0;
    do begin @(negedge clk_out); c++; end while (fifo_empty[1] && c < 5);
    chk("lat empty", 32'(fifo_empty[1]), 32'd0);
    @(negedge clk_out);
    chk("lat rd", 32'(fifo_rd), 32'b0010);
    chk("lat valid t1", 32'(m_valid), 32'd0);
    @(negedge clk_out);
    chk("lat rd off", 32'(fifo_rd), 32'd0);
    chk("lat valid t2", 32'(m_valid), 32'd0);
    @(negedge clk_out);
    chk("lat valid t3", 32'(m_valid), 32'd1);
    chk("lat data", 32'(m_data), 32'hA5);
    chk("lat ch", 32'(m_ch), 32'd1);
    @(negedge clk_out);
    chk("lat busy low", 32'(busy), 32'd0);
    drain("single", 1'b0, sg, ss);

    // Backpressure on ch3
    @(posedge clk_out); #1; m_ready = 1'b0;
    sg = got.size(); ss = nstrobe;
    @(negedge clk_out); load(3, 8'h3C, 1'b1);
    c = 0;
    while (!m_valid && c < 20) begin @(negedge clk_out); c++; end
    chk("bp valid", 32'(m_valid), 32'd1);
    repeat (10) @(negedge clk_out);
    chk("bp held", 32'(m_valid), 32'd1);
    chk("bp data", 32'(m_data), 32'h3C);
    chk("bp ch", 32'(m_ch), 32'd3);
    chk("bp one strobe", 32'(nstrobe - ss), 32'd1);
    drain("bp", 1'b0, sg, ss);

    // Burst split: ch0 x6, ch2 x2
    sg = got.size(); ss = nstrobe;
    @(negedge clk_out);
    for (int i = 0; i < 6; i++) load(0, 8'(8'h10 + i), 1'b1);
    for (int i = 0; i < 2; i++) load(2, 8'(8'h20 + i), 1'b1);
    drain("burst", 1'b0, sg, ss);

    // Pointer to 3, then wrap between ch3 and ch0
    sg = got.size(); ss = nstrobe;
    @(negedge clk_out); load(2, 8'h2F, 1'b1);
    drain("ptr3", 1'b0, sg, ss);
    sg = got.size(); ss = nstrobe;
    @(negedge clk_out); load(0, 8'h40, 1'b1); load(3, 8'h43, 1'b1);
    drain("wrap", 1'b0, sg, ss);

    // ch0 x5, ch1 x1
    sg = got.size(); ss = nstrobe;
    @(negedge clk_out);
    for (int i = 0; i < 5; i++) load(0, 8'(8'h60 + i), 1'b1);
    load(1, 8'h71, 1'b1);
    drain("prio", 1'b0, sg, ss);

    // Randomized contents and backpressure
    for (int r = 0; r < 8; r++) begin
      sg = got.size(); ss = nstrobe;
      @(negedge clk_out);
      for (int k = 0; k < CH; k++) begin
        n = $urandom_range(0, 5);
        for (int j = 0; j < n; j++) load(k, 8'($urandom), 1'b1);
      end
      drain("rnd", 1'b1, sg, ss);
    end

    // Reset while in CAP; move rr_ptr off 0 first
    sg = got.size(); ss = nstrobe;
    @(negedge clk_out); load(0, 8'h01, 1'b1);
    drain("pre rst", 1'b0, sg, ss);
    @(negedge clk_out); load(2, 8'h77, 1'b0);
    c = 0;
    do begin @(negedge clk_out); c++; end while (!fifo_rd[2] && c < 10);
    chk("rst strobe seen", 32'(fifo_rd[2]), 32'd1);
    @(posedge clk_out); #1;
    chk("cap busy", 32'(busy), 32'd1);
    arst = 1'b1;
    #1;
    chk("arst fifo_rd", 32'(fifo_rd), 32'd0);
    chk("arst m_valid", 32'(m_valid), 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst m_data", 32'(m_data), 32'd0);
    mptr = 0;
    @(negedge clk_out); arst = 1'b0;
    sg = got.size(); ss = nstrobe;
    @(negedge clk_out); load(0, 8'h50, 1'b1); load(3, 8'h53, 1'b1);
    drain("post rst", 1'b0, sg, ss);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
